// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer/deserializer state encodings, frame width
// and the default bit period used by uart_tx and uart_rx.
package uart_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 87;

  typedef enum logic [2:0] {
    UART_IDLE    = 3'd0,
    UART_START   = 3'd1,
    UART_DATA    = 3'd2,
    UART_STOP    = 3'd3,
    UART_CLEANUP = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO holding bytes waiting for the serializer.
// Pushes into a full FIFO and pops from an empty one are ignored.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int FIFO_DEPTH = 4,
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                      i_Clock,
  input  logic                      i_Rst_n,
  input  logic                      push,
  input  logic [UART_DATA_BITS-1:0] push_data,
  input  logic                      pop,
  output logic [UART_DATA_BITS-1:0] pop_data,
  output logic                      full,
  output logic                      empty,
  output logic [CNT_W-1:0]          count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [UART_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic                      push_ok;
  logic                      pop_ok;

  // full/empty come from the registered count only, so a pop in the same
  // cycle never makes room for a push.
  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge i_Clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: byte FIFO in front of a start/data/stop
// serializer, each bit held CLKS_PER_BIT clocks on a registered line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                      i_Clock,
  input  logic                      i_Rst_n,
  input  logic                      i_Tx_DV,
  input  logic [UART_DATA_BITS-1:0] i_Tx_Byte,
  output logic                      o_Tx_Ready,
  output logic                      o_Tx_Serial,
  output logic                      o_Tx_Active,
  output logic                      o_Tx_Done
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(UART_DATA_BITS);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_BITS - 1);

  uart_state_e               state, state_n;
  logic [CNT_W-1:0]          clk_cnt, clk_cnt_n;
  logic [BIT_W-1:0]          bit_idx, bit_idx_n;
  logic [UART_DATA_BITS-1:0] shift, shift_n;
  logic                      serial_n;
  logic                      bit_end;

  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_head;
  logic [FCNT_W-1:0]         unused_fifo_count;

  // Write handshake: i_Tx_DV is the valid, o_Tx_Ready the ready; a byte is
  // taken on any rising edge where both are high, otherwise it is dropped.
  uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .i_Clock   (i_Clock),
    .i_Rst_n   (i_Rst_n),
    .push      (i_Tx_DV),
    .push_data (i_Tx_Byte),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (unused_fifo_count)
  );

  assign o_Tx_Ready = !fifo_full;
  assign bit_end    = (clk_cnt == CNT_MAX);

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= UART_IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_Tx_Serial <= 1'b1;
    end else begin
      state       <= state_n;
      clk_cnt     <= clk_cnt_n;
      bit_idx     <= bit_idx_n;
      shift       <= shift_n;
      o_Tx_Serial <= serial_n;
    end
  end

  // The line value for the next bit is decided here so it leaves a flop.
  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    serial_n  = o_Tx_Serial;
    case (state)
      UART_IDLE: begin
        serial_n  = 1'b1;
        clk_cnt_n = '0;
        bit_idx_n = '0;
        if (!fifo_empty) begin
          shift_n  = fifo_head;
          serial_n = 1'b0;
          state_n  = UART_START;
        end
      end
      UART_START: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          serial_n  = shift[0];
          state_n   = UART_DATA;
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end
      UART_DATA: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          if (bit_idx == BIT_LAST) begin
            serial_n = 1'b1;
            state_n  = UART_STOP;
          end else begin
            bit_idx_n = bit_idx + BIT_W'(1);
            shift_n   = shift >> 1;
            serial_n  = shift[1];
          end
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end
      UART_STOP: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          state_n   = UART_CLEANUP;
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end
      UART_CLEANUP: begin
        serial_n = 1'b1;
        state_n  = UART_IDLE;
      end
      default: begin
        serial_n  = 1'b1;
        clk_cnt_n = '0;
        bit_idx_n = '0;
        state_n   = UART_IDLE;
      end
    endcase
  end

  always_comb begin
    o_Tx_Active = (state == UART_START) || (state == UART_DATA) || (state == UART_STOP);
    o_Tx_Done   = (state == UART_CLEANUP);
    fifo_pop    = (state == UART_IDLE) && !fifo_empty;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Buffered UART transmitter: the send side of the 8N1 serial link whose receive side is `uart_rx`. It accepts bytes from the APB peripheral logic through a valid/ready handshake and holds them in a small FIFO. Each byte is serialized as one start bit, eight data bits LSB-first and one stop bit. Each bit lasts exactly CLKS_PER_BIT clocks, so the output decodes cleanly in a `uart_rx` using the same parameter.

## Interface
- CLKS_PER_BIT, 87, clocks per serial bit; must be ≥ 2.
- FIFO_DEPTH, 4, transmit FIFO entries; power of two, ≥ 2.

- i_Clock  input  1  system clock, rising edge.
- i_Rst_n  input  1  asynchronous, active-low reset.
- i_Tx_DV  input  1  write strobe; byte accepted on a rising edge where i_Tx_DV && o_Tx_Ready.
- i_Tx_Byte  input  8  byte to send; sampled with i_Tx_DV.
- o_Tx_Ready  output  1  FIFO not full.
- o_Tx_Serial  output  1  serial line, registered; idle high.
- o_Tx_Active  output  1  high while a frame is being shifted (START, DATA, STOP).
- o_Tx_Done  output  1  one-clock pulse after each completed stop bit.

## Operation
- The FIFO is written on accepted strobes and popped by the serializer. If i_Tx_DV is high while o_Tx_Ready is low, the byte is dropped silently and the FIFO is unchanged.
- The serializer state machine uses 3-bit states IDLE=0, START=1, DATA=2, STOP=3, CLEANUP=4. Any other encoding goes to IDLE.
- IDLE: o_Tx_Serial=1 and the bit counter is cleared. If the FIFO is non-empty, on the next edge the serializer loads the head byte into the shift register, pops the FIFO, drives o_Tx_Serial=0 and goes to START.
- START: holds 0 for CLKS_PER_BIT clocks, then drives bit 0 and goes to DATA.
- DATA: each bit is held CLKS_PER_BIT clocks, with bit index 0..7. After bit 7 the serializer drives 1 and goes to STOP.
- STOP: holds 1 for CLKS_PER_BIT clocks, then goes to CLEANUP.
- CLEANUP: lasts one clock. o_Tx_Done=1, o_Tx_Serial=1, then the serializer returns to IDLE.
- Clock counter width is clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and is cleared at every bit boundary.
- FIFO occupancy counter width is clog2(FIFO_DEPTH+1). Read and write pointers are clog2(FIFO_DEPTH) bits and wrap naturally.
- A simultaneous push and pop leaves the count unchanged.
- o_Tx_Ready is derived from the registered count only. A pop in the same cycle does not raise it, so a full FIFO rejects a write even when it is popped that cycle.

## Timing
- Reset values: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=1. The FIFO is empty and the state is IDLE.
- Reset asserted mid-frame: the line returns high immediately (asynchronously), queued bytes are discarded and no o_Tx_Done pulse occurs.
- Latency: byte accepted into an empty idle block at edge N → o_Tx_Serial falls at edge N+1.
- Frame length: 10×CLKS_PER_BIT clocks from the start-bit falling edge to the end of the stop bit.
- Back-to-back bytes: the line is high for CLKS_PER_BIT+2 clocks (stop, CLEANUP, IDLE). Consecutive start-bit falls are exactly 10×CLKS_PER_BIT+2 clocks apart.
- o_Tx_Done is high exactly one cycle per frame, during CLEANUP.
- o_Tx_Active is high from START entry through the last STOP cycle, and low in CLEANUP and IDLE.
- o_Tx_Ready falls the cycle after the write that fills the FIFO, and rises the cycle after the pop that frees an entry.

## Structure
- Shared package `uart_pkg`:
  - state encodings (shared with `uart_rx`);
  - UART_DATA_BITS=8;
  - default CLKS_PER_BIT.
- Sub-module `uart_tx_fifo`: synchronous FIFO with parameter FIFO_DEPTH; push/pop/full/empty/count ports; same clock and reset.
- Top level contains the serializer state machine, clock counter, bit index and shift register.

## Test plan
- Set CLKS_PER_BIT=4. Write 0xA5 → line reads 0, then 1,0,1,0,0,1,0,1, then 1. Each level is held 4 clocks, the fall occurs one clock after the write, and a single o_Tx_Done pulse follows 40 clocks after the fall.
- Write 0x00 and 0xFF back-to-back → start-bit falls are 42 clocks apart and a `uart_rx` loopback (CLKS_PER_BIT=4) returns 0x00 then 0xFF.
- Write 6 bytes in consecutive cycles with FIFO_DEPTH=4:
  - the first byte is popped one edge after it is accepted, freeing its slot for later writes;
  - o_Tx_Ready falls once the FIFO fills, and writes while it is low are dropped;
  - the bytes actually sent match, in order, exactly those accepted while o_Tx_Ready was high.
- Assert i_Rst_n low during DATA bit 3 → o_Tx_Serial is 1 without waiting for a clock edge, o_Tx_Ready=1, no o_Tx_Done pulse, and no further frames after release.
- With the FIFO full and serializer IDLE, raise i_Tx_DV in the same cycle the head is popped → the write is rejected and the count drops to FIFO_DEPTH-1.
- Hold i_Tx_DV low for 1000 clocks after reset → o_Tx_Serial stays 1, and o_Tx_Active and o_Tx_Done stay 0.
